// File: rtl/mipi_packet_parser.sv
// -----------------------------------------------------------------------------
// mipi_packet_parser
//
// Front end of the CSI-2 receive path. Takes the merged two-lane 16-bit word
// stream, decodes the 4-byte packet header (DI, WC, ECC), checks the header
// ECC, and then does one of the following:
//    - forwards the payload of pixel long packets as raw_data/raw_vld
//    - silently skips other long packets
//    - turns Frame Start / Frame End short packets into single-cycle pulses
// Only one packet is parsed per burst. Any words that follow the packet in the
// same burst are discarded.
//
// Ports
//    clk          single clock
//    resetn       asynchronous, active-low reset
//    word_vld     input word valid, contiguous for the length of a burst
//    word_data    [7:0] lane0 (earlier) byte, [15:8] lane1 byte
//    raw_vld      payload word valid (registered, 1-cycle latency)
//    raw_data     payload word; holds its last value when raw_vld is low
//    raw_vsync    pulse on accepted Frame Start
//    frame_end    pulse on accepted Frame End
//    packet_done  pulse at the end of every accepted packet
//    hdr_err      pulse when a header is rejected (ECC or illegal pixel WC)
//    pkt_abort    pulse when a burst ends in the middle of a packet
// -----------------------------------------------------------------------------
module mipi_packet_parser #(
   parameter logic [5:0]  PIXEL_DT = 6'h2A,
   parameter logic [1:0]  VC       = 2'd0,
   parameter logic [15:0] MAX_WC   = 16'd8192
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        word_vld,
   input  logic [15:0] word_data,
   output logic        raw_vld,
   output logic [15:0] raw_data,
   output logic        raw_vsync,
   output logic        frame_end,
   output logic        packet_done,
   output logic        hdr_err,
   output logic        pkt_abort
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD,
      S_SKIP,
      S_CRC,
      S_DROP
   } state_t;

   state_t      state_q,       state_d;
   logic [7:0]  di_q,          di_d;
   logic [7:0]  wc_lsb_q,      wc_lsb_d;
   logic [14:0] remain_q,      remain_d;
   logic        raw_vld_q,     raw_vld_d;
   logic [15:0] raw_data_q,    raw_data_d;
   logic        raw_vsync_q,   raw_vsync_d;
   logic        frame_end_q,   frame_end_d;
   logic        packet_done_q, packet_done_d;
   logic        hdr_err_q,     hdr_err_d;
   logic        pkt_abort_q,   pkt_abort_d;

   // CSI-2 header ECC: each parity bit is the XOR of a fixed subset of the
   // 24 header bits {WC MSB, WC LSB, DI}.
   function automatic logic [5:0] calc_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction

   // Header fields as they look while W1 is on the input.
   logic [15:0] hdr_wc;
   logic [7:0]  hdr_ecc;
   logic [5:0]  hdr_dt;
   logic        hdr_ecc_ok;
   logic        hdr_wc_bad;

   assign hdr_wc     = {word_data[7:0], wc_lsb_q};
   assign hdr_ecc    = word_data[15:8];
   assign hdr_dt     = di_q[5:0];
   assign hdr_ecc_ok = (hdr_ecc == {2'b00, calc_ecc({hdr_wc, di_q})});
   assign hdr_wc_bad = hdr_wc[0] || (hdr_wc == 16'd0) || (hdr_wc > MAX_WC);

   // Next-state and next-output logic. Pulses default low every cycle;
   // raw_data defaults to its old value so it holds between payload words.
   always_comb begin
      state_d       = state_q;
      di_d          = di_q;
      wc_lsb_d      = wc_lsb_q;
      remain_d      = remain_q;
      raw_vld_d     = 1'b0;
      raw_data_d    = raw_data_q;
      raw_vsync_d   = 1'b0;
      frame_end_d   = 1'b0;
      packet_done_d = 1'b0;
      hdr_err_d     = 1'b0;
      pkt_abort_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (word_vld) begin
               di_d     = word_data[7:0];
               wc_lsb_d = word_data[15:8];
               state_d  = S_HDR;
            end
         end

         S_HDR: begin
            if (!word_vld) begin
               pkt_abort_d = 1'b1;
               state_d     = S_IDLE;
            end else if (!hdr_ecc_ok) begin
               hdr_err_d = 1'b1;
               state_d   = S_DROP;
            end else if (di_q[7:6] != VC) begin
               state_d = S_DROP;
            end else if (hdr_dt < 6'h10) begin
               raw_vsync_d   = (hdr_dt == 6'h00);
               frame_end_d   = (hdr_dt == 6'h01);
               packet_done_d = 1'b1;
               state_d       = S_DROP;
            end else if (hdr_dt == PIXEL_DT) begin
               if (hdr_wc_bad) begin
                  hdr_err_d = 1'b1;
                  state_d   = S_DROP;
               end else begin
                  remain_d = hdr_wc[15:1];
                  state_d  = S_PAYLOAD;
               end
            end else begin
               remain_d = hdr_wc[15:1];
               state_d  = S_SKIP;
            end
         end

         // Skipped packets count exactly like pixel packets but never drive
         // raw_vld. The <= 1 compare also covers a skipped WC below 2, which
         // would otherwise start the count at zero.
         S_PAYLOAD, S_SKIP: begin
            if (!word_vld) begin
               pkt_abort_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               if (state_q == S_PAYLOAD) begin
                  raw_vld_d  = 1'b1;
                  raw_data_d = word_data;
               end
               remain_d = remain_q - 15'd1;
               if (remain_q <= 15'd1) begin
                  state_d = S_CRC;
               end
            end
         end

         // Packet CRC is consumed but not checked.
         S_CRC: begin
            if (!word_vld) begin
               pkt_abort_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               packet_done_d = 1'b1;
               state_d       = S_DROP;
            end
         end

         S_DROP: begin
            if (!word_vld) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs. The asynchronous reset discards any
   // partial packet without emitting pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         di_q          <= 8'd0;
         wc_lsb_q      <= 8'd0;
         remain_q      <= 15'd0;
         raw_vld_q     <= 1'b0;
         raw_data_q    <= 16'd0;
         raw_vsync_q   <= 1'b0;
         frame_end_q   <= 1'b0;
         packet_done_q <= 1'b0;
         hdr_err_q     <= 1'b0;
         pkt_abort_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         di_q          <= di_d;
         wc_lsb_q      <= wc_lsb_d;
         remain_q      <= remain_d;
         raw_vld_q     <= raw_vld_d;
         raw_data_q    <= raw_data_d;
         raw_vsync_q   <= raw_vsync_d;
         frame_end_q   <= frame_end_d;
         packet_done_q <= packet_done_d;
         hdr_err_q     <= hdr_err_d;
         pkt_abort_q   <= pkt_abort_d;
      end
   end

   assign raw_vld     = raw_vld_q;
   assign raw_data    = raw_data_q;
   assign raw_vsync   = raw_vsync_q;
   assign frame_end   = frame_end_q;
   assign packet_done = packet_done_q;
   assign hdr_err     = hdr_err_q;
   assign pkt_abort   = pkt_abort_q;

endmodule
